// File: rtl/branch_predictor_bht_if.sv
// Shared types and the decode/execute/fetch bundle for branch_predictor_bht.
//   master : pipeline side (drives decode/execute info, receives redirects)
//   slave  : predictor side
// Signals: stall, branchType, PCID, imm (decode); f3EXE, immEXE, aluOut,
// zeroFlag/negFlag/neguFlag (execute); flush, hold, branch, bypass, PCnext,
// predTaken, branchCount, mispredictCount (predictor outputs).
package branch_predictor_bht_pkg;
    typedef enum logic [1:0] {
        NON         = 2'd0,
        JAL         = 2'd1,
        JALR        = 2'd2,
        CONDITIONAL = 2'd3
    } branch_type_t;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_signals_t;
endpackage

interface branch_predictor_bht_if
    import branch_predictor_bht_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic            stall;
    branch_type_t    branchType;
    logic [31:0]     PCID;
    logic [31:0]     imm;
    branch_signals_t f3EXE;
    logic [31:0]     immEXE;
    logic [31:0]     aluOut;
    logic            zeroFlag;
    logic            negFlag;
    logic            neguFlag;
    logic            flush;
    logic            hold;
    logic            branch;
    logic            bypass;
    logic [31:0]     PCnext;
    logic            predTaken;
    logic [CNT_W-1:0] branchCount;
    logic [CNT_W-1:0] mispredictCount;

    modport master (
        output stall, branchType, PCID, imm, f3EXE, immEXE, aluOut,
               zeroFlag, negFlag, neguFlag,
        input  flush, hold, branch, bypass, PCnext, predTaken,
               branchCount, mispredictCount
    );

    modport slave (
        input  stall, branchType, PCID, imm, f3EXE, immEXE, aluOut,
               zeroFlag, negFlag, neguFlag,
        output flush, hold, branch, bypass, PCnext, predTaken,
               branchCount, mispredictCount
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// PC-indexed saturating-counter branch predictor with execute-stage resolution.
// Decode looks up the table and redirects on JAL / predicted-taken branches;
// execute resolves conditionals and JALR, overriding decode on a mispredict.
// Ports:
//   Clock, nReset : clock, asynchronous active-low reset
//   bus (slave)   : decode/execute inputs, redirect/flush/hold outputs,
//                   branch and mispredict performance counters
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int INDEX_LSB = 2,
    parameter int RESET_CTR = 2**(CTR_BITS-1)-1,
    parameter int CNT_W     = 32
) (
    input logic                   Clock,
    input logic                   nReset,
    branch_predictor_bht_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(RESET_CTR);

    typedef struct packed {
        logic             valid;
        branch_type_t     bType;
        logic [IDX_W-1:0] idx;
        logic             pred;
        logic [31:0]      pc;
    } exe_t;

    logic [ENTRIES-1:0][CTR_BITS-1:0] ctrTable;
    exe_t                             exeQ;
    logic [CNT_W-1:0]                 branchCnt;
    logic [CNT_W-1:0]                 mispredictCnt;

    logic [IDX_W-1:0] idxID;
    logic             predID;
    logic             taken;
    logic             exeCond;
    logic             exeJalr;
    logic             exeMiss;

    logic             flushO;
    logic             holdO;
    logic             branchO;
    logic             bypassO;
    logic [31:0]      pcNextO;
    logic             predO;

    // Lookup reads the registered table only: a same-cycle update to the
    // same index is not forwarded.
    assign idxID  = bus.PCID[INDEX_LSB +: IDX_W];
    assign predID = ctrTable[idxID][CTR_BITS-1];

    always_comb begin
        taken = 1'b0;
        case (bus.f3EXE)
            BEQ:     taken = bus.zeroFlag;
            BNE:     taken = !bus.zeroFlag;
            BLT:     taken = bus.negFlag;
            BGE:     taken = !bus.negFlag;
            BLTU:    taken = bus.neguFlag;
            BGEU:    taken = !bus.neguFlag;
            default: taken = 1'b0;
        endcase
    end

    assign exeCond = exeQ.valid && (exeQ.bType == CONDITIONAL);
    assign exeJalr = exeQ.valid && (exeQ.bType == JALR);
    assign exeMiss = exeCond && (taken != exeQ.pred);

    // Execute redirects win over decode; decode-driven outputs only apply
    // when execute has nothing to correct.
    always_comb begin
        flushO  = 1'b0;
        holdO   = 1'b0;
        branchO = 1'b0;
        bypassO = 1'b0;
        pcNextO = 32'd0;
        predO   = 1'b0;
        if (nReset) begin
            if (exeJalr) begin
                flushO  = 1'b1;
                branchO = 1'b1;
                bypassO = 1'b1;
                pcNextO = bus.aluOut;
            end else if (exeMiss) begin
                flushO  = 1'b1;
                branchO = 1'b1;
                pcNextO = taken ? bus.immEXE : exeQ.pc + 32'd4;
            end else begin
                case (bus.branchType)
                    JAL: begin
                        branchO = 1'b1;
                        pcNextO = bus.imm;
                    end
                    JALR: holdO = 1'b1;
                    CONDITIONAL: begin
                        predO = predID;
                        if (predID) begin
                            branchO = 1'b1;
                            pcNextO = bus.imm;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < ENTRIES; i++) ctrTable[i] <= CTR_RST;
            exeQ          <= '0;
            branchCnt     <= '0;
            mispredictCnt <= '0;
        end else if (!bus.stall) begin
            // A stalled resolve keeps its redirect up but trains only once,
            // on the edge that releases it.
            if (exeCond) begin
                if (taken && ctrTable[exeQ.idx] != CTR_MAX)
                    ctrTable[exeQ.idx] <= ctrTable[exeQ.idx] + 1'b1;
                else if (!taken && ctrTable[exeQ.idx] != '0)
                    ctrTable[exeQ.idx] <= ctrTable[exeQ.idx] - 1'b1;
                branchCnt <= branchCnt + 1'b1;
                if (exeMiss) mispredictCnt <= mispredictCnt + 1'b1;
            end
            // A squashed decode instruction never enters execute.
            exeQ.valid <= (bus.branchType != NON) && !flushO;
            exeQ.bType <= bus.branchType;
            exeQ.idx   <= idxID;
            exeQ.pred  <= predID;
            exeQ.pc    <= bus.PCID;
        end
    end

    assign bus.flush           = flushO;
    assign bus.hold            = holdO;
    assign bus.branch          = branchO;
    assign bus.bypass          = bypassO;
    assign bus.PCnext          = pcNextO;
    assign bus.predTaken       = predO;
    assign bus.branchCount     = branchCnt;
    assign bus.mispredictCount = mispredictCnt;
endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;
    import branch_predictor_bht_pkg::*;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;
    always #5 Clock = ~Clock;

    branch_predictor_bht_if #(.CNT_W(32)) bus();

    branch_predictor_bht #(
        .ENTRIES(16), .CTR_BITS(2), .INDEX_LSB(2), .RESET_CTR(1), .CNT_W(32)
    ) dut (
        .Clock (Clock),
        .nReset(nReset),
        .bus   (bus.slave)
    );

    // flag bits: {flush, hold, branch, bypass, predTaken}
    localparam logic [4:0] F = 5'b10000, H = 5'b01000, B = 5'b00100,
                           Y = 5'b00010, P = 5'b00001, Z = 5'b00000;

    typedef struct {
        string       name;
        logic [4:0]  flags;
        logic [31:0] pcn;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge Clock) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [4:0] act;
            e   = q.pop_front();
            act = {bus.flush, bus.hold, bus.branch, bus.bypass, bus.predTaken};
            checks++;
            if (act !== e.flags || bus.PCnext !== e.pcn ||
                bus.branchCount !== e.bc || bus.mispredictCount !== e.mc) begin
                errors++;
                $display("FAIL %s: got fl/ho/br/by/pt=%b PCnext=%h bc=%0d mc=%0d, want %b %h %0d %0d",
                         e.name, act, bus.PCnext, bus.branchCount, bus.mispredictCount,
                         e.flags, e.pcn, e.bc, e.mc);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clr();
        bus.stall      = 1'b0;
        bus.branchType = NON;
        bus.PCID       = '0;
        bus.imm        = '0;
        bus.f3EXE      = BEQ;
        bus.immEXE     = '0;
        bus.aluOut     = '0;
        bus.zeroFlag   = 1'b0;
        bus.negFlag    = 1'b0;
        bus.neguFlag   = 1'b0;
    endtask

    task automatic dec(input branch_type_t t, input logic [31:0] pc, input logic [31:0] im);
        bus.branchType = t;
        bus.PCID       = pc;
        bus.imm        = im;
    endtask

    task automatic exe(input branch_signals_t f3, input logic [31:0] ie,
                       input logic z, input logic n, input logic nu);
        bus.f3EXE    = f3;
        bus.immEXE   = ie;
        bus.zeroFlag = z;
        bus.negFlag  = n;
        bus.neguFlag = nu;
    endtask

    task automatic want(input string nm, input logic [4:0] fl, input logic [31:0] pcn,
                        input int bc, input int mc);
        exp_t e;
        e.name  = nm;
        e.flags = fl;
        e.pcn   = pcn;
        e.bc    = bc;
        e.mc    = mc;
        q.push_back(e);
    endtask

    initial begin
        clr();
        nReset = 1'b0;
        bus.branchType = JAL;
        bus.imm        = 32'h55;
        tick(); want("reset_outputs_zero", Z, 0, 0, 0);

        // BEQ at 0x40, idx 0, counter 1 -> not taken, then mispredicts taken
        tick(); nReset = 1'b1; clr(); dec(CONDITIONAL, 32'h40, 32'h80);
        want("beq1_lookup", Z, 0, 0, 0);
        tick(); clr(); exe(BEQ, 32'h80, 1, 0, 0);
        want("beq1_mispredict", F|B, 32'h80, 0, 0);
        tick(); clr(); dec(CONDITIONAL, 32'h40, 32'h80);
        want("beq2_pred_taken", B|P, 32'h80, 1, 1);
        tick(); clr(); exe(BEQ, 32'h80, 0, 0, 0);
        want("beq2_fallthrough", F|B, 32'h44, 1, 1);
        tick(); clr(); dec(JAL, 32'h10, 32'h700);
        want("jal_decode", B, 32'h700, 2, 2);
        tick(); clr();
        want("jal_in_exe_quiet", Z, 0, 2, 2);

        // Four taken BNE at 0x100 (idx 0, aliases 0x40): counter 1->2->3->3->3
        for (int k = 0; k < 4; k++) begin
            tick(); clr(); dec(CONDITIONAL, 32'h100, 32'h200);
            want("bne_lookup", (k == 0) ? Z : (B|P), (k == 0) ? 32'h0 : 32'h200,
                 2 + k, (k == 0) ? 2 : 3);
            tick(); clr(); exe(BNE, 32'h200, 0, 0, 0);
            want("bne_taken", (k == 0) ? (F|B) : Z, (k == 0) ? 32'h200 : 32'h0,
                 2 + k, (k == 0) ? 2 : 3);
        end
        tick(); clr(); dec(CONDITIONAL, 32'h100, 32'h200);
        want("bne_sat_lookup", B|P, 32'h200, 6, 3);
        tick(); clr(); exe(BNE, 32'h200, 1, 0, 0);
        want("bne_not_taken", F|B, 32'h104, 6, 3);
        tick(); clr(); dec(CONDITIONAL, 32'h100, 32'h200);
        want("bne_still_taken", B|P, 32'h200, 7, 4);
        // 0x80 shares idx 0; lookup sees pre-update counter 2
        tick(); clr(); dec(CONDITIONAL, 32'h80, 32'h300); exe(BNE, 32'h200, 0, 0, 0);
        want("alias_0x80_taken", B|P, 32'h300, 7, 4);
        tick(); clr(); exe(BEQ, 32'h300, 1, 0, 0);
        want("alias_resolve_ok", Z, 0, 8, 4);

        // JALR: hold in decode, bypass redirect in execute, JAL behind it squashed
        tick(); clr(); dec(JALR, 32'h200, 32'h0);
        want("jalr_hold", H, 0, 9, 4);
        tick(); clr(); dec(JAL, 32'h210, 32'h999); bus.aluOut = 32'h1234;
        want("jalr_redirect", F|B|Y, 32'h1234, 9, 4);
        tick(); clr();
        want("jal_squashed", Z, 0, 9, 4);

        // BLT at 0x44 (idx 1) mispredicts while stalled three cycles
        tick(); clr(); dec(CONDITIONAL, 32'h44, 32'h500);
        want("blt_lookup", Z, 0, 9, 4);
        for (int k = 0; k < 3; k++) begin
            tick(); clr(); bus.stall = 1'b1; exe(BLT, 32'h500, 0, 1, 0);
            dec(CONDITIONAL, 32'h40, 32'h80);
            want("blt_stall_redirect", F|B, 32'h500, 9, 4);
        end
        tick(); clr(); exe(BLT, 32'h500, 0, 1, 0); dec(CONDITIONAL, 32'h40, 32'h80);
        want("blt_release", F|B, 32'h500, 9, 4);
        tick(); clr();
        want("blt_counted_once", Z, 0, 10, 5);

        // Second BLT predicted taken, mispredicts, reset lands mid-stall
        tick(); clr(); dec(CONDITIONAL, 32'h44, 32'h500);
        want("blt2_pred_taken", B|P, 32'h500, 10, 5);
        tick(); clr(); bus.stall = 1'b1; exe(BLT, 32'h500, 0, 0, 0);
        want("blt2_stall_miss", F|B, 32'h48, 10, 5);
        tick(); clr(); bus.stall = 1'b1; exe(BLT, 32'h500, 0, 0, 0); nReset = 1'b0;
        want("reset_mid_stall", Z, 0, 0, 0);
        tick(); nReset = 1'b1; clr(); dec(CONDITIONAL, 32'h44, 32'h500);
        want("post_reset_table", Z, 0, 0, 0);
        tick(); clr(); exe(BLT, 32'h500, 0, 0, 0);
        want("post_reset_resolve", Z, 0, 0, 0);

        // Idx 2 (0x08): two not-taken resolves must saturate at 0
        tick(); clr(); dec(CONDITIONAL, 32'h08, 32'h600);
        want("sat0_lookup1", Z, 0, 1, 0);
        tick(); clr(); exe(BEQ, 32'h600, 0, 0, 0);
        want("sat0_nt1", Z, 0, 1, 0);
        tick(); clr(); dec(CONDITIONAL, 32'h08, 32'h600);
        want("sat0_lookup2", Z, 0, 2, 0);
        tick(); clr(); exe(BEQ, 32'h600, 0, 0, 0);
        want("sat0_nt2", Z, 0, 2, 0);
        tick(); clr(); dec(CONDITIONAL, 32'h08, 32'h600);
        want("sat0_lookup3", Z, 0, 3, 0);
        tick(); clr(); exe(BEQ, 32'h600, 1, 0, 0);
        want("sat0_taken_miss", F|B, 32'h600, 3, 0);
        tick(); clr();
        want("final_idle", Z, 0, 4, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clock);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
